// File: rtl/display_pkg.sv
// display_pkg: shared constants for the eight-digit seven-segment driver.
//   SEG_0..SEG_9, SEG_DASH : active-high g..a patterns (bit 6 = g, bit 0 = a)
//   NUM_DIGITS             : number of scanned digits
//   cnt_width()            : counter width for a divide-by-n counter (min 1)
package display_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // A divide-by-1 counter still needs one bit to exist as a signal.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcd7seg_decode.sv
// bcd7seg_decode: combinational BCD digit to seven-segment pattern.
//   digit_i [3:0] : BCD digit; values A..F render as a dash
//   blank_i       : 1 = all segments and dp off
//   dp_i          : decimal point request
//   seg_o   [7:0] : active-high pattern, [6:0] = g..a, [7] = dp
module bcd7seg_decode
  import display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  logic [6:0] glyph;

  always_comb begin
    glyph = SEG_DASH;
    case (digit_i)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  end

  assign seg_o = blank_i ? 8'h00 : {dp_i, glyph};

endmodule

// File: rtl/bcd_seg_display.sv
// bcd_seg_display: multiplexed eight-digit seven-segment driver for a packed
// BCD word. Snapshots bcd_in every UPDATE_DIV cycles (unless hold), scans one
// digit per SCAN_DIV cycles with a one-cycle dark gap between digits, blanks
// leading zeros and shows a dash for non-BCD digits.
//   clk_100M     : system clock
//   rst          : asynchronous active-low reset
//   bcd_in [31:0]: packed BCD, digit i = bcd_in[4i+3:4i]
//   hold         : 1 = keep the current snapshot
//   dp_sel [7:0] : decimal point enable per digit
//   seg    [7:0] : registered segment drive, [6:0] = g..a, [7] = dp
//   an     [7:0] : registered digit enables, an[i] = digit i
module bcd_seg_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int UPDATE_DIV = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic [31:0] bcd_in,
  input  logic        hold,
  input  logic [7:0]  dp_sel,
  output logic [7:0]  seg,
  output logic [7:0]  an
);

  localparam int SW = cnt_width(SCAN_DIV);
  localparam int UW = cnt_width(UPDATE_DIV);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [UW-1:0] UPD_LAST  = UW'(UPDATE_DIV - 1);
  localparam logic [7:0]    BUS_OFF   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [UW-1:0] upd_cnt_q, upd_cnt_d;
  logic [2:0]    digit_idx_q, digit_idx_d;
  logic [31:0]   snap_q, snap_d;
  logic          dead_q, dead_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic          tick;
  logic          upd_tc;
  logic [7:0]    lz;
  logic          blank;
  logic [3:0]    cur_digit;
  logic [7:0]    pat;
  logic [7:0]    an_hi;

  assign tick   = (scan_cnt_q == SCAN_LAST);
  assign upd_tc = (upd_cnt_q == UPD_LAST);

  always_comb begin
    scan_cnt_d  = tick ? '0 : scan_cnt_q + 1'b1;
    upd_cnt_d   = upd_tc ? '0 : upd_cnt_q + 1'b1;
    digit_idx_d = tick ? digit_idx_q + 3'd1 : digit_idx_q;
    snap_d      = (upd_tc && !hold) ? bcd_in : snap_q;
    dead_d      = tick;
  end

  // lz[i]: digits i..7 are all zero with no decimal point requested there.
  always_comb begin
    lz    = '0;
    lz[7] = (snap_q[31:28] == 4'd0) && !dp_sel[7];
    for (int i = 6; i >= 0; i--) begin
      lz[i] = lz[i+1] && (snap_q[4*i +: 4] == 4'd0) && !dp_sel[i];
    end
  end

  assign cur_digit = snap_q[{digit_idx_q, 2'b00} +: 4];
  assign blank     = (digit_idx_q != 3'd0) && lz[digit_idx_q];

  bcd7seg_decode u_decode (
    .digit_i (cur_digit),
    .blank_i (blank),
    .dp_i    (dp_sel[digit_idx_q]),
    .seg_o   (pat)
  );

  always_comb begin
    an_hi = dead_q ? 8'h00 : (8'b1 << digit_idx_q);
    an_d  = (ACTIVE_LOW != 0) ? ~an_hi : an_hi;
    seg_d = (ACTIVE_LOW != 0) ? ~pat : pat;
  end

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      scan_cnt_q  <= '0;
      upd_cnt_q   <= '0;
      digit_idx_q <= '0;
      snap_q      <= '0;
      dead_q      <= 1'b0;
      an_q        <= BUS_OFF;
      seg_q       <= BUS_OFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      upd_cnt_q   <= upd_cnt_d;
      digit_idx_q <= digit_idx_d;
      snap_q      <= snap_d;
      dead_q      <= dead_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_bcd_seg_display.sv
// tb_bcd_seg_display: directed self-checking bench for bcd_seg_display with
// SCAN_DIV=4, UPDATE_DIV=16, ACTIVE_LOW=1. Outputs are sampled on the falling
// clock edge; inputs change on the falling edge.
module tb_bcd_seg_display;

  logic        clk_100M;
  logic        rst;
  logic [31:0] bcd_in;
  logic        hold;
  logic [7:0]  dp_sel;
  logic [7:0]  seg;
  logic [7:0]  an;

  int tests;
  int failed;

  bcd_seg_display #(
    .SCAN_DIV   (4),
    .UPDATE_DIV (16),
    .ACTIVE_LOW (1)
  ) dut (
    .clk_100M (clk_100M),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .hold     (hold),
    .dp_sel   (dp_sel),
    .seg      (seg),
    .an       (an)
  );

  // clock / reset
  initial clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_100M);
  endtask

  // Wait (bounded) until digit d is lit, then check its segment pattern.
  task automatic check_digit(input string tag, input int d, input logic [7:0] exp_seg);
    logic [7:0] want_an;
    bit         found;
    want_an = ~(8'b1 << d);
    found   = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk_100M);
      if (an === want_an) found = 1'b1;
    end
    tests++;
    assert (found)
    else begin
      failed++;
      $error("FAIL %s_wait digit=%0d never lit, an=%h", tag, d, an);
    end
    if (found) check8(tag, seg, exp_seg);
  endtask

  initial begin : stim
    int         last_dark;
    int         darks;
    int         prev_d;
    int         cur_d;
    logic [7:0] frame_an [32];

    tests  = 0;
    failed = 0;
    rst    = 1'b0;
    bcd_in = 32'h0001_2345;
    hold   = 1'b0;
    dp_sel = 8'h00;

    // reset state
    cycles(2);
    check8("reset_an", an, 8'hFF);
    check8("reset_seg", seg, 8'hFF);
    rst = 1'b1;
    @(negedge clk_100M);
    check8("first_an", an, 8'hFE);
    check8("first_seg", seg, 8'hC0);

    // 00012345: digits 0..4 = 5,4,3,2,1; 5..7 blank
    cycles(20);
    check_digit("v1_d0", 0, 8'h92);
    check_digit("v1_d1", 1, 8'h99);
    check_digit("v1_d2", 2, 8'hB0);
    check_digit("v1_d3", 3, 8'hA4);
    check_digit("v1_d4", 4, 8'hF9);
    check_digit("v1_d5", 5, 8'hFF);
    check_digit("v1_d6", 6, 8'hFF);
    check_digit("v1_d7", 7, 8'hFF);

    // scan rotation over one frame
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_100M);
      frame_an[i] = an;
    end
    darks     = 0;
    last_dark = -1;
    prev_d    = -1;
    for (int i = 0; i < 32; i++) begin
      if (frame_an[i] === 8'hFF) begin
        if (last_dark >= 0) begin
          tests++;
          assert (i - last_dark == 4)
          else begin
            failed++;
            $error("FAIL dark_spacing observed=%0d expected=4", i - last_dark);
          end
        end
        last_dark = i;
        darks++;
      end else begin
        cur_d = -1;
        for (int k = 0; k < 8; k++) if (frame_an[i] === ~(8'b1 << k)) cur_d = k;
        tests++;
        assert (cur_d >= 0)
        else begin
          failed++;
          $error("FAIL an_onehot observed=%h expected=one low bit", frame_an[i]);
        end
        if (cur_d >= 0 && prev_d >= 0 && cur_d != prev_d) begin
          tests++;
          assert (cur_d == (prev_d + 1) % 8)
          else begin
            failed++;
            $error("FAIL an_order observed=%0d expected=%0d", cur_d, (prev_d + 1) % 8);
          end
        end
        if (cur_d >= 0) prev_d = cur_d;
      end
    end
    tests++;
    assert (darks == 8)
    else begin
      failed++;
      $error("FAIL dark_count observed=%0d expected=8", darks);
    end

    // zero with dp on digit 2: digits 0..2 show 0, digit 2 dp lit
    bcd_in = 32'h0000_0000;
    dp_sel = 8'h04;
    cycles(20);
    check_digit("v2_d0", 0, 8'hC0);
    check_digit("v2_d1", 1, 8'hC0);
    check_digit("v2_d2", 2, 8'h40);
    check_digit("v2_d3", 3, 8'hFF);
    check_digit("v2_d7", 7, 8'hFF);

    // 0000A0F9: d0=9, d1=F dash, d2=0, d3=A dash, d4..7 blank
    bcd_in = 32'h0000_A0F9;
    dp_sel = 8'h00;
    cycles(20);
    check_digit("v3_d0", 0, 8'h90);
    check_digit("v3_d1", 1, 8'hBF);
    check_digit("v3_d2", 2, 8'hC0);
    check_digit("v3_d3", 3, 8'hBF);
    check_digit("v3_d4", 4, 8'hFF);

    // hold freezes the snapshot across three update periods
    hold   = 1'b1;
    bcd_in = 32'h8765_4321;
    cycles(48);
    check_digit("hold_d0", 0, 8'h90);
    check_digit("hold_d3", 3, 8'hBF);
    check_digit("hold_d7", 7, 8'hFF);

    // release: new value visible within 16+2 cycles
    hold = 1'b0;
    cycles(18);
    check_digit("rel_d0", 0, 8'hF9);
    check_digit("rel_d1", 1, 8'hA4);
    check_digit("rel_d2", 2, 8'hB0);
    check_digit("rel_d3", 3, 8'h99);
    check_digit("rel_d4", 4, 8'h92);
    check_digit("rel_d5", 5, 8'h82);
    check_digit("rel_d6", 6, 8'hF8);
    check_digit("rel_d7", 7, 8'h80);

    // asynchronous reset mid-slot on digit 5
    check_digit("pre_rst_d5", 5, 8'h82);
    rst = 1'b0;
    #1;
    check8("async_an", an, 8'hFF);
    check8("async_seg", seg, 8'hFF);
    cycles(3);
    rst = 1'b1;
    @(negedge clk_100M);
    check8("restart_an", an, 8'hFE);
    check8("restart_seg", seg, 8'hC0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
